// File: rtl/parking_pkg.sv
// Shared types and constants for the parking guidance path.
// The round-robin slot search is enabled by defining SLOT_ALLOC_ROUND_ROBIN_EN.
package parking_pkg;

  localparam int          BLOCK_W    = 3;
  localparam logic [2:0]  BLOCK_NONE = 3'b111;
  localparam int          MAX_SLOTS  = 7;

  typedef enum logic [1:0] {
    IDLE,
    ALLOC,
    GUIDE
  } alloc_state_t;

  // Result of a free-slot search over the occupancy map.
  typedef struct packed {
    logic                found;
    logic [BLOCK_W-1:0]  slot;
  } search_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and
// rising-edge pulse. A clean press yields a single 1-cycle pulse
// DEBOUNCE_CYC+2 cycles after the raw edge; holding yields no more.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has persisted; pulse on accepted rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        stable_q <= sync2_q;
        pulse_q  <= sync2_q;
        cnt_q    <= '0;
      end else begin
        pulse_q  <= 1'b0;
        cnt_q    <= cnt_q + 1'b1;
      end
    end else begin
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/parking_slot_allocator.sv
// Parking slot allocator: owns the occupancy map, allocates a free slot
// per debounced entry press and shows its Block code for HOLD_CYC cycles.
// Define SLOT_ALLOC_ROUND_ROBIN_EN for a rotating search start instead of
// lowest-index-first.
module parking_slot_allocator
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS    = 7,
  parameter int DEBOUNCE_CYC = 4,
  parameter int HOLD_CYC     = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 entry_btn,
  input  logic                 exit_btn,
  input  logic [BLOCK_W-1:0]   exit_slot,
  output logic [BLOCK_W-1:0]   block,
  output logic                 guide_active,
  output logic [MAX_SLOTS-1:0] occupancy,
  output logic [BLOCK_W-1:0]   free_count,
  output logic                 lot_full,
  output logic                 alloc_pulse,
  output logic                 reject_pulse,
  output logic                 exit_err
);

  localparam int HOLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

  logic                 entry_acc;
  logic                 exit_acc;

  alloc_state_t         state_q;
  logic [BLOCK_W-1:0]   block_q;
  logic                 guide_q;
  logic [MAX_SLOTS-1:0] occ_q;
  logic [HOLD_W-1:0]    hold_q;
  logic                 pending_q;
  logic                 alloc_q;
  logic                 reject_q;
  logic                 err_q;

  logic                 exit_ok_d;
  logic [MAX_SLOTS-1:0] occ_exit_d;
  logic [BLOCK_W-1:0]   start_d;
  search_t              search_d;
  logic [BLOCK_W-1:0]   free_d;

`ifdef SLOT_ALLOC_ROUND_ROBIN_EN
  logic [BLOCK_W-1:0]   ptr_q;
`endif

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_entry_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (entry_btn),
    .pulse_o (entry_acc)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_exit_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (exit_btn),
    .pulse_o (exit_acc)
  );

  // First free slot at or after start, wrapping within the configured slots.
  function automatic search_t find_free(input logic [MAX_SLOTS-1:0] occ,
                                        input logic [BLOCK_W-1:0]   start);
    search_t r;
    int      idx;
    r.found = 1'b0;
    r.slot  = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      idx = (int'(start) + k) % NUM_SLOTS;
      if (!r.found && !occ[idx]) begin
        r.found = 1'b1;
        r.slot  = BLOCK_W'(idx);
      end
    end
    return r;
  endfunction

  // Exit is applied before any allocation in the same cycle, so the
  // search sees the post-exit map and may hand out the slot just freed.
  always_comb begin
    logic [MAX_SLOTS:0] occ_ext;
    occ_ext   = {1'b0, occ_q};
    exit_ok_d = exit_acc && (exit_slot < BLOCK_W'(NUM_SLOTS)) && occ_ext[exit_slot];
    if (exit_ok_d) begin
      occ_ext[exit_slot] = 1'b0;
    end
    occ_exit_d = occ_ext[MAX_SLOTS-1:0];
`ifdef SLOT_ALLOC_ROUND_ROBIN_EN
    start_d = ptr_q;
`else
    start_d = '0;
`endif
    search_d = find_free(occ_exit_d, start_d);
  end

  // Free slots counted from the registered map.
  always_comb begin
    free_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!occ_q[i]) begin
        free_d = free_d + 1'b1;
      end
    end
  end

  // Allocation FSM with registered display outputs and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      block_q   <= BLOCK_NONE;
      guide_q   <= 1'b0;
      occ_q     <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
      alloc_q   <= 1'b0;
      reject_q  <= 1'b0;
      err_q     <= 1'b0;
`ifdef SLOT_ALLOC_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      alloc_q  <= 1'b0;
      reject_q <= 1'b0;
      err_q    <= exit_acc && !exit_ok_d;
      occ_q    <= occ_exit_d;
      unique case (state_q)
        IDLE: begin
          if (entry_acc || pending_q) begin
            state_q   <= ALLOC;
            pending_q <= 1'b0;
          end
        end
        ALLOC: begin
          if (entry_acc) begin
            pending_q <= 1'b1;
          end
          if (search_d.found) begin
            occ_q   <= occ_exit_d | (MAX_SLOTS'(1) << search_d.slot);
            block_q <= search_d.slot;
            guide_q <= 1'b1;
            alloc_q <= 1'b1;
            hold_q  <= HOLD_W'(HOLD_CYC - 1);
            state_q <= GUIDE;
`ifdef SLOT_ALLOC_ROUND_ROBIN_EN
            ptr_q   <= (search_d.slot == BLOCK_W'(NUM_SLOTS - 1)) ? '0
                                                                  : search_d.slot + 1'b1;
`endif
          end else begin
            reject_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        GUIDE: begin
          if (hold_q == '0) begin
            block_q <= BLOCK_NONE;
            guide_q <= 1'b0;
            if (pending_q || entry_acc) begin
              state_q   <= ALLOC;
              pending_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            hold_q <= hold_q - 1'b1;
            if (entry_acc) begin
              pending_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign block        = block_q;
  assign guide_active = guide_q;
  assign occupancy    = occ_q;
  assign free_count   = free_d;
  assign lot_full     = (free_d == '0);
  assign alloc_pulse  = alloc_q;
  assign reject_pulse = reject_q;
  assign exit_err     = err_q;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Bench for parking_slot_allocator: directed scenarios plus randomized
// button traffic, compared every cycle against a timestamp-based model.
module tb_parking_slot_allocator;

  localparam int NS = 7;
  localparam int D  = 4;
  localparam int H  = 64;
  localparam int LAT = D + 3;  // raw rise -> edge where the FSM sees the accept

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry_btn = 1'b0;
  logic       exit_btn = 1'b0;
  logic [2:0] exit_slot = 3'd0;
  logic [2:0] block;
  logic       guide_active;
  logic [6:0] occupancy;
  logic [2:0] free_count;
  logic       lot_full;
  logic       alloc_pulse;
  logic       reject_pulse;
  logic       exit_err;

  parking_slot_allocator #(
    .NUM_SLOTS(NS), .DEBOUNCE_CYC(D), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .entry_btn(entry_btn), .exit_btn(exit_btn),
    .exit_slot(exit_slot), .block(block), .guide_active(guide_active),
    .occupancy(occupancy), .free_count(free_count), .lot_full(lot_full),
    .alloc_pulse(alloc_pulse), .reject_pulse(reject_pulse), .exit_err(exit_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state
  int       n = 0;
  bit [7:0] m_occ;
  int       m_block;
  bit       m_guide, m_try, m_pending, m_alloc, m_rej, m_err;
  int       m_win_end;
  int       m_ptr;
  int       ent_at, ext_at, ext_slot_m;
  int       alloc_seen;
  int       last_alloc_blk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, n);
  endtask

  task automatic model_reset();
    m_occ = '0; m_block = 7; m_guide = 0; m_try = 0; m_pending = 0;
    m_alloc = 0; m_rej = 0; m_err = 0; m_win_end = 0; m_ptr = 0;
    ent_at = -1; ext_at = -1; ext_slot_m = 0;
  endtask

  // One clock edge of the lot's rules: exits first, then allocation / window timing.
  task automatic model_step();
    bit ent, ext;
    int s;
    ent = (n == ent_at);
    ext = (n == ext_at);
    m_alloc = 0; m_rej = 0; m_err = 0;
    if (ext) begin
      if (ext_slot_m < NS && m_occ[ext_slot_m]) m_occ[ext_slot_m] = 1'b0;
      else m_err = 1;
    end
    if (m_try) begin
      m_try = 0;
      if (ent) m_pending = 1;
      s = -1;
      for (int k = 0; k < NS; k++) begin
        if (s < 0 && !m_occ[(m_ptr + k) % NS]) s = (m_ptr + k) % NS;
      end
      if (s >= 0) begin
        m_occ[s] = 1'b1; m_block = s; m_guide = 1; m_alloc = 1; m_win_end = n + H;
`ifdef SLOT_ALLOC_ROUND_ROBIN_EN
        m_ptr = (s + 1) % NS;
`endif
      end else begin
        m_rej = 1;
      end
    end else if (m_guide) begin
      if (n == m_win_end) begin
        m_guide = 0; m_block = 7;
        if (m_pending || ent) begin m_try = 1; m_pending = 0; end
      end else if (ent) begin
        m_pending = 1;
      end
    end else if (ent || m_pending) begin
      m_try = 1; m_pending = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    model_step();
    @(negedge clk);
    check("block", 32'(block), 32'(m_block));
    check("guide_active", 32'(guide_active), 32'(m_guide));
    check("occupancy", 32'(occupancy), 32'(m_occ[6:0]));
    check("free_count", 32'(free_count), 32'(NS - $countones(m_occ)));
    check("lot_full", 32'(lot_full), 32'($countones(m_occ) == NS));
    check("alloc_pulse", 32'(alloc_pulse), 32'(m_alloc));
    check("reject_pulse", 32'(reject_pulse), 32'(m_rej));
    check("exit_err", 32'(exit_err), 32'(m_err));
    if (alloc_pulse) begin alloc_seen++; last_alloc_blk = int'(block); end
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic press(input bit is_exit, input int slot, input int bounces);
    if (is_exit) exit_slot = 3'(slot);
    for (int b = 0; b < bounces; b++) begin
      if (is_exit) exit_btn = 1'b1; else entry_btn = 1'b1;
      tick();
      if (is_exit) exit_btn = 1'b0; else entry_btn = 1'b0;
      tick();
    end
    if (is_exit) begin exit_btn = 1'b1; ext_at = n + LAT; ext_slot_m = slot; end
    else begin entry_btn = 1'b1; ent_at = n + LAT; end
    idle(D + 6);
    entry_btn = 1'b0; exit_btn = 1'b0;
    idle(D + 6);
  endtask

  // Entry first, exit one cycle later: the exit lands on the ALLOC edge.
  task automatic press_pair(input int slot);
    exit_slot = 3'(slot);
    entry_btn = 1'b1; ent_at = n + LAT;
    tick();
    exit_btn = 1'b1; ext_at = n + LAT; ext_slot_m = slot;
    idle(D + 6);
    entry_btn = 1'b0; exit_btn = 1'b0;
    idle(D + 6);
  endtask

  task automatic settle();
    int guard = 0;
    while ((m_guide || m_try || m_pending) && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) check("settle_timeout", 32'(guard), 32'(0));
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    entry_btn = 1'b0; exit_btn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    model_reset();
    alloc_seen = 0; last_alloc_blk = 7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_block", 32'(block), 32'h7);
    check("rst_occ", 32'(occupancy), 32'h0);
    check("rst_free", 32'(free_count), 32'd7);
    check("rst_full", 32'(lot_full), 32'd0);
    check("rst_guide", 32'(guide_active), 32'd0);
    check("rst_pulses", 32'({alloc_pulse, reject_pulse, exit_err}), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Bounced entry: a single allocation of slot 0
    a0 = alloc_seen;
    press(0, 0, 3);
    settle();
    check("bounce_allocs", 32'(alloc_seen - a0), 32'd1);
    check("bounce_occ", 32'(occupancy), 32'h01);

    // Fill the lot, then one more entry is refused
    for (int i = 1; i < NS; i++) begin press(0, 0, 0); settle(); end
    check("fill_occ", 32'(occupancy), 32'h7f);
    press(0, 0, 1);
    settle();
    check("full_flag", 32'(lot_full), 32'd1);
    check("full_block", 32'(block), 32'h7);

    // Free slot 3, next entry reuses it
    press(1, 3, 0);
    check("exit3_full", 32'(lot_full), 32'd0);
    press(0, 0, 0);
    settle();
    check("reuse3_blk", 32'(last_alloc_blk), 32'd3);

    // Exit and allocation on the same edge on a full lot
    press_pair(5);
    settle();
    check("pair_blk", 32'(last_alloc_blk), 32'd5);
    check("pair_occ", 32'(occupancy), 32'h7f);

    // Free 0 and 1; three entries during one window -> two allocations
    press(1, 0, 0);
    press(1, 1, 0);
    a0 = alloc_seen;
    press(0, 0, 0);
    press(0, 0, 2);
    press(0, 0, 0);
    settle();
    check("pend_allocs", 32'(alloc_seen - a0), 32'd2);
    check("pend_blk", 32'(last_alloc_blk), 32'd1);

    // Exit of a free slot and of an out-of-range slot
    press(1, 5, 0);
    press(1, 5, 0);
    press(1, 7, 0);
    check("err_occ", 32'(occupancy), 32'h5f);

    // Search order after freeing a low slot
    do_reset();
    for (int i = 0; i < 3; i++) begin press(0, 0, 0); settle(); end
    press(1, 0, 0);
    press(0, 0, 0);
    settle();
`ifdef SLOT_ALLOC_ROUND_ROBIN_EN
    check("search_slot", 32'(last_alloc_blk), 32'd3);
`else
    check("search_slot", 32'(last_alloc_blk), 32'd0);
`endif

    // Randomized traffic
    for (int it = 0; it < 50; it++) begin
      case ($urandom_range(0, 3))
        0, 1: press(0, 0, int'($urandom_range(0, 3)));
        2:    press(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        default: press_pair(int'($urandom_range(0, 7)));
      endcase
      idle(int'($urandom_range(0, 30)));
    end
    settle();

    // Reset in the middle of a guidance window
    do_reset();
    press(0, 0, 0);
    idle(10);
    check("pre_rst_guide", 32'(guide_active), 32'(m_guide));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_block", 32'(block), 32'h7);
    check("async_rst_occ", 32'(occupancy), 32'h0);
    check("async_rst_guide", 32'(guide_active), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(3);
    press(0, 0, 0);
    settle();
    check("post_rst_blk", 32'(last_alloc_blk), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
